// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
//
// Executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles (WIDTH iterations plus one
// sign-fix cycle) and services MTHI/MTLO in a single edge.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   start  - issue strobe from EX, qualified by a recognised Funct
//   Funct  - R-type funct field (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   in_a   - rs operand (multiplicand / dividend / MTHI-MTLO data)
//   in_b   - rt operand (multiplier / divisor)
//   busy   - mul/div in progress; start is ignored while high
//   done   - one-cycle pulse after HI/LO are written by a mul/div
//   hi, lo - HI/LO registers, read combinationally for MFHI/MFLO
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [5:0] FnMthi  = 6'h11;
    localparam logic [5:0] FnMtlo  = 6'h13;
    localparam logic [5:0] FnMult  = 6'h18;
    localparam logic [5:0] FnMultu = 6'h19;
    localparam logic [5:0] FnDiv   = 6'h1A;
    localparam logic [5:0] FnDivu  = 6'h1B;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic               is_div_q;
    logic               neg_res_q;   // negate product / quotient
    logic               neg_rem_q;   // negate remainder (dividend was negative)
    logic               dz_q;
    logic [WIDTH-1:0]   orig_a_q;
    logic [WIDTH-1:0]   opnd_q;      // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] acc_q;       // product accumulator; low half is quotient for divide
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    // Issue-time decode and operand magnitudes
    logic               issue_signed;
    logic               issue_div;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    // Per-iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        issue_signed = (Funct == FnMult) || (Funct == FnDiv);
        issue_div    = (Funct == FnDiv) || (Funct == FnDivu);
        a_abs        = (issue_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        b_abs        = (issue_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    end

    always_comb begin
        // Shift-add: conditionally add the multiplicand into the upper half,
        // then shift the whole accumulator right, carry included.
        mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                            : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder.
        div_trial = {rem_q, acc_q[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, opnd_q};
        // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
        div_diff  = div_trial[WIDTH-1:0] - opnd_q;
        div_rem   = div_ge ? div_diff : div_trial[WIDTH-1:0];
        div_quo   = {acc_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            orig_a_q  <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        case (Funct)
                            FnMult, FnMultu, FnDiv, FnDivu: begin
                                is_div_q  <= issue_div;
                                neg_res_q <= issue_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                                neg_rem_q <= issue_signed && in_a[WIDTH-1];
                                dz_q      <= issue_div && (in_b == '0);
                                orig_a_q  <= in_a;
                                opnd_q    <= issue_div ? b_abs : a_abs;
                                acc_q     <= {{WIDTH{1'b0}}, (issue_div ? a_abs : b_abs)};
                                rem_q     <= '0;
                                cnt_q     <= '0;
                                busy_q    <= 1'b1;
                                state_q   <= StCalc;
                            end
                            FnMthi:  hi_q <= in_a;
                            FnMtlo:  lo_q <= in_a;
                            default: ;
                        endcase
                    end
                end
                StCalc: begin
                    if (is_div_q) begin
                        acc_q <= {acc_q[2*WIDTH-1:WIDTH], div_quo};
                        rem_q <= div_rem;
                    end else begin
                        acc_q <= mul_next;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (is_div_q) begin
                        if (dz_q) begin
                            lo_q <= '1;
                            hi_q <= orig_a_q;
                        end else begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): reset state, MTHI/MTLO,
// signed/unsigned multiply and divide, back-to-back issue, divide by zero,
// signed overflow, start-while-busy and mid-operation reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .Funct (funct),
        .in_a  (in_a),
        .in_b  (in_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        funct = f;
        in_a  = a;
        in_b  = b;
    endtask

    // Called at the negedge where start is driven. Returns posedges from the
    // start edge to done (or -1 on timeout) and the number of busy cycles.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                in_a  = 32'hA5A5_5A5A;  // operands must be ignored after issue
                in_b  = 32'h0F0F_F0F0;
            end
            if (busy) bcnt++;
            if (done) begin
                lat = n - 1;
                return;
            end
        end
    endtask

    int lat;
    int bcnt;
    int done_seen;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        funct = 6'h00;
        in_a  = '0;
        in_b  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        // MTHI / MTLO
        drive(6'h11, 32'h1234_5678, 32'h0);
        @(negedge clk);
        start = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'h0);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        drive(6'h13, 32'h9ABC_DEF0, 32'h0);
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_hi", hi, 32'h1234_5678);
        check("mtlo_busy", {31'b0, busy}, 32'd0);
        check("mtlo_done", {31'b0, done}, 32'd0);

        // MULTU max*max
        drive(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("multu_lat", lat, 32'd33);
        check("multu_busy_cycles", bcnt, 32'd33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        check("multu_busy_at_done", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("multu_done_pulse", {31'b0, done}, 32'd0);

        // MULT -3*7, then DIV -7/2 issued in the done cycle
        drive(6'h18, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, bcnt);
        check("mult_lat", lat, 32'd33);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        drive(6'h1A, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt);
        check("div_b2b_lat", lat, 32'd33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        @(negedge clk);

        // DIVU by zero
        drive(6'h1B, 32'd100, 32'd0);
        wait_done(lat, bcnt);
        check("divu_dz_lat", lat, 32'd33);
        check("divu_dz_hi", hi, 32'h0000_0064);
        check("divu_dz_lo", lo, 32'hFFFF_FFFF);
        @(negedge clk);

        // Signed overflow
        drive(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);
        @(negedge clk);

        // DIV negative dividend by zero: hi keeps the raw dividend
        drive(6'h1A, 32'hFFFF_FFFB, 32'd0);
        wait_done(lat, bcnt);
        check("div_dz_hi", hi, 32'hFFFF_FFFB);
        check("div_dz_lo", lo, 32'hFFFF_FFFF);
        @(negedge clk);

        // DIVU 50/7 with MTHI while busy, then mid-operation reset
        drive(6'h1B, 32'd50, 32'd7);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 5) drive(6'h11, 32'h0000_DEAD, 32'h0);
            if (n == 6) begin
                start = 1'b0;
                check("busy_mthi_hi", hi, 32'hFFFF_FFFB);
                check("busy_mthi_busy", {31'b0, busy}, 32'd1);
            end
        end
        reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);

        drive(6'h1B, 32'd50, 32'd7);
        wait_done(lat, bcnt);
        check("divu_fresh_lat", lat, 32'd33);
        check("divu_fresh_lo", lo, 32'd7);
        check("divu_fresh_hi", hi, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit in the EX stage, beside the main ALU.
- Decodes the same R-type Funct field that drives ALU function selection.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and services MTHI/MTLO.
- Exposes HI/LO to the EX-stage mux for MFHI/MFLO. The hazard unit uses busy to stall the pipeline.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  issue strobe from EX; valid only with a recognised Funct
- Funct  in  6  instruction funct: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
- in_a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- in_b  in  WIDTH  rt operand (multiplier / divisor)
- busy  out  1  operation in progress; start is ignored while high
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div
- hi  out  WIDTH  HI register; read combinationally for MFHI
- lo  out  WIDTH  LO register; read combinationally for MFLO

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; counter and working registers cleared.
  - Mid-operation reset aborts the operation with no HI/LO update.
- States: IDLE, CALC, FIX.
- IDLE, on start=1:
  - MULT/MULTU/DIV/DIVU: latch opcode, signedness, |in_a|, |in_b| (unsigned ops take raw values), result signs, divide-by-zero flag and original in_a. Go to CALC; busy=1 from the next cycle.
  - MTHI/MTLO: hi<=in_a (or lo<=in_a) at that edge; remain in IDLE; busy and done stay 0.
  - Any other Funct, or start=0: no action.
- CALC: one iteration per clock for exactly WIDTH clocks; counter runs 0..WIDTH-1, then FIX.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle; the WIDTH+1-bit partial remainder is compared against the divisor.
- FIX (1 clock): apply sign correction, write hi/lo at exit edge, busy->0, done=1 for the following cycle only. Return to IDLE.
- Latency: start edge E0 -> hi/lo valid and done=1 after edge E(WIDTH+1), i.e. 33 for WIDTH=32. busy high during cycles E0..E(WIDTH+1).
- start is accepted in the same cycle done is high (back-to-back).
- start while busy: ignored entirely (no relatch, no MTHI/MTLO write).
- Operands are sampled only at E0; later in_a/in_b changes are irrelevant.
- Signed multiply: 64-bit magnitude product; two's-complement negate when operand signs differ. hi=upper, lo=lower.
- Signed divide:
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
  - lo=quotient, hi=remainder.
- Divide by zero (DIV or DIVU, in_b=0): full latency; lo=all ones, hi=original in_a.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No exception.
- Unsigned ops never negate.

Test Plan:
- Reset release, no start -> busy=0, done=0, hi=lo=0. Then MTHI in_a=0x12345678, then MTLO in_a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0 one edge after each; busy never rises.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done 33 cycles after start, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT (-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV (-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Second start issued in the done cycle is accepted.
- DIVU 100/0 -> hi=0x00000064, lo=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 50/7; pulse start with MTHI 0xDEAD at cycle 5; drop reset at cycle 10 -> MTHI ignored. Reset gives busy=0 and hi=lo=0 immediately, with no done pulse. A fresh DIVU 50/7 after release gives lo=7, hi=1.
